// File: rtl/myip_s_axil_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : myip_s_axil_regfile
//  Purpose  : AXI4-Lite slave holding four 32-bit software registers at byte
//             offsets 0x0/0x4/0x8/0xC. The AW and W channels are accepted
//             independently into one-entry holding buffers. A write commits
//             once both buffers are full and the B channel can take a
//             response. All responses are OKAY. The register contents and
//             per-register commit strobes are exported to the core logic.
//  Ports    : ACLK / ARESETN    - clock, asynchronous active-low reset
//             S_AXI_AW*         - write address channel (AWPROT ignored)
//             S_AXI_W*          - write data channel with byte strobes
//             S_AXI_B*          - write response channel
//             S_AXI_AR*         - read address channel (ARPROT ignored)
//             S_AXI_R*          - read data channel
//             REG_OUT           - {reg3, reg2, reg1, reg0}, registered
//             REG_WR            - one-cycle pulse per register on commit
//  Revision : 1.0 - initial release
// ============================================================================
module myip_s_axil_regfile #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  // Write address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  // Write data channel
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  // Write response channel
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  // Read address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  // Read data channel
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  // Core-side register view
  output logic [4*C_S_AXI_DATA_WIDTH-1:0]   REG_OUT,
  output logic [3:0]                        REG_WR
);

  localparam int NUM_REGS = 4;
  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int STRB_W   = C_S_AXI_DATA_WIDTH / 8;
  localparam int SEL_LSB  = 2;   // byte offset bits [1:0] are ignored
  localparam int SEL_W    = 2;   // bits [3:2] pick one of four registers

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  // Write address buffer
  logic                         aw_full_q,  aw_full_d;
  logic [SEL_W-1:0]             aw_sel_q,   aw_sel_d;
  logic                         awready_q,  awready_d;
  // Write data buffer
  logic                         w_full_q,   w_full_d;
  logic [DW-1:0]                w_data_q,   w_data_d;
  logic [STRB_W-1:0]            w_strb_q,   w_strb_d;
  logic                         wready_q,   wready_d;
  // Write response
  logic                         bvalid_q,   bvalid_d;
  // Read path
  logic                         arready_q,  arready_d;
  logic                         rvalid_q,   rvalid_d;
  logic [DW-1:0]                rdata_q,    rdata_d;
  // Register file and commit strobes
  logic [NUM_REGS-1:0][DW-1:0]  regs_q,     regs_d;
  logic [NUM_REGS-1:0]          reg_wr_q,   reg_wr_d;

  // --------------------------------------------------------------------------
  // Handshake qualifiers
  // --------------------------------------------------------------------------
  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic ar_hs;
  logic r_hs;
  logic commit;

  assign aw_hs = S_AXI_AWVALID && awready_q;
  assign w_hs  = S_AXI_WVALID  && wready_q;
  assign b_hs  = bvalid_q      && S_AXI_BREADY;
  assign ar_hs = S_AXI_ARVALID && arready_q;
  assign r_hs  = rvalid_q      && S_AXI_RREADY;

  // A commit needs both halves of the write and a free response slot. The
  // response slot is free either when nothing is pending or when the pending
  // response is being accepted on this very edge.
  assign commit = aw_full_q && w_full_q && (!bvalid_q || S_AXI_BREADY);

  // --------------------------------------------------------------------------
  // Write path next-state
  // --------------------------------------------------------------------------
  // A buffer can never be loaded and drained on the same edge: loading needs
  // READY high (buffer empty) while a commit needs the buffer full.
  always_comb begin
    aw_full_d = aw_full_q;
    aw_sel_d  = aw_sel_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    regs_d    = regs_q;
    reg_wr_d  = '0;

    if (commit) begin
      aw_full_d = 1'b0;
    end else if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_sel_d  = S_AXI_AWADDR[SEL_LSB +: SEL_W];
    end

    if (commit) begin
      w_full_d = 1'b0;
    end else if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = S_AXI_WDATA;
      w_strb_d = S_AXI_WSTRB;
    end

    if (commit) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_strb_q[b]) begin
          regs_d[aw_sel_q][b*8 +: 8] = w_data_q[b*8 +: 8];
        end
      end
      reg_wr_d[aw_sel_q] = 1'b1;
    end

    // A new commit re-arms BVALID even if the previous response is leaving.
    if (commit) begin
      bvalid_d = 1'b1;
    end else if (b_hs) begin
      bvalid_d = 1'b0;
    end
  end

  // READY is registered and mirrors the emptiness of the buffer after the
  // edge, so it stays low through reset and rises on the first edge after.
  assign awready_d = !aw_full_d;
  assign wready_d  = !w_full_d;

  // --------------------------------------------------------------------------
  // Read path next-state
  // --------------------------------------------------------------------------
  // RDATA samples the current register contents, so a write committing on
  // the same edge is not visible to this read.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;

    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = regs_q[S_AXI_ARADDR[SEL_LSB +: SEL_W]];
    end else if (r_hs) begin
      rvalid_d = 1'b0;
    end
  end

  // Only one read may be outstanding; ARREADY returns with the R handshake.
  assign arready_d = !rvalid_d;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_full_q <= 1'b0;
      aw_sel_q  <= '0;
      awready_q <= 1'b0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      regs_q    <= '0;
      reg_wr_q  <= '0;
    end else begin
      aw_full_q <= aw_full_d;
      aw_sel_q  <= aw_sel_d;
      awready_q <= awready_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      regs_q    <= regs_d;
      reg_wr_q  <= reg_wr_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign REG_WR        = reg_wr_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
    assign REG_OUT[i*DW +: DW] = regs_q[i];
  end

  // Protection bits and the byte-offset address bits carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[SEL_LSB-1:0], S_AXI_ARADDR[SEL_LSB-1:0]};

endmodule
`default_nettype wire

// File: tb/tb_myip_s_axil_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_myip_s_axil_regfile
//  Purpose  : Self-checking bench for myip_s_axil_regfile. Keeps a simple
//             array model of the four registers and compares bus responses,
//             REG_OUT and REG_WR against it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_myip_s_axil_regfile;

  logic         ACLK = 1'b0;
  logic         ARESETN = 1'b0;
  logic [3:0]   S_AXI_AWADDR = '0;
  logic [2:0]   S_AXI_AWPROT = '0;
  logic         S_AXI_AWVALID = 1'b0;
  logic         S_AXI_AWREADY;
  logic [31:0]  S_AXI_WDATA = '0;
  logic [3:0]   S_AXI_WSTRB = '0;
  logic         S_AXI_WVALID = 1'b0;
  logic         S_AXI_WREADY;
  logic [1:0]   S_AXI_BRESP;
  logic         S_AXI_BVALID;
  logic         S_AXI_BREADY = 1'b1;
  logic [3:0]   S_AXI_ARADDR = '0;
  logic [2:0]   S_AXI_ARPROT = '0;
  logic         S_AXI_ARVALID = 1'b0;
  logic         S_AXI_ARREADY;
  logic [31:0]  S_AXI_RDATA;
  logic [1:0]   S_AXI_RRESP;
  logic         S_AXI_RVALID;
  logic         S_AXI_RREADY = 1'b1;
  logic [127:0] REG_OUT;
  logic [3:0]   REG_WR;

  int errors = 0;
  int checks = 0;

  logic [31:0] model [4];

  always #5 ACLK = ~ACLK;

  myip_s_axil_regfile #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4)
  ) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .REG_OUT       (REG_OUT),
    .REG_WR        (REG_WR)
  );

  // --------------------------------------------------------------------------
  // Reference model helpers
  // --------------------------------------------------------------------------
  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [127:0] model_flat();
    return {model[3], model[2], model[1], model[0]};
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Stimulus helpers (all start and end 1 time unit after a rising edge)
  // --------------------------------------------------------------------------
  task automatic send_aw_w(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input bit do_aw, input bit do_w);
    bit aw_done, w_done, aw_hs, w_hs;
    int n;
    aw_done = !do_aw;
    w_done  = !do_w;
    if (do_aw) begin
      S_AXI_AWADDR  = addr;
      S_AXI_AWPROT  = 3'($urandom);
      S_AXI_AWVALID = 1'b1;
    end
    if (do_w) begin
      S_AXI_WDATA  = data;
      S_AXI_WSTRB  = strb;
      S_AXI_WVALID = 1'b1;
    end
    n = 0;
    while (!(aw_done && w_done) && n < 50) begin
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
      tick();
      if (aw_hs) begin S_AXI_AWVALID = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin S_AXI_WVALID  = 1'b0; w_done  = 1'b1; end
      n++;
    end
    if (!(aw_done && w_done)) begin
      errors++; checks++;
      $display("FAIL aw_w_handshake_timeout: aw_done=%0b w_done=%0b required 1 1", aw_done, w_done);
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
    end
  endtask

  task automatic wait_b(output logic [1:0] resp, output logic [3:0] wr,
                        output logic [127:0] rout);
    int n;
    n = 0;
    while (!S_AXI_BVALID && n < 50) begin tick(); n++; end
    if (!S_AXI_BVALID) begin
      errors++; checks++;
      $display("FAIL bvalid_timeout: BVALID=0 required 1");
    end
    resp = S_AXI_BRESP;
    wr   = REG_WR;
    rout = REG_OUT;
    if (S_AXI_BREADY) tick();
  endtask

  task automatic do_read(input logic [3:0] addr, output logic [31:0] data,
                         output logic [1:0] resp);
    bit hs;
    int n;
    S_AXI_ARADDR  = addr;
    S_AXI_ARPROT  = 3'($urandom);
    S_AXI_ARVALID = 1'b1;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 50) begin
      hs = S_AXI_ARVALID && S_AXI_ARREADY;
      tick();
      n++;
    end
    S_AXI_ARVALID = 1'b0;
    if (!hs || !S_AXI_RVALID) begin
      errors++; checks++;
      $display("FAIL read_timeout: ar_hs=%0b RVALID=%0b required 1 1", hs, S_AXI_RVALID);
    end
    data = S_AXI_RDATA;
    resp = S_AXI_RRESP;
    if (S_AXI_RREADY) tick();
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    logic [177:0] outs;
    for (int i = 0; i < 4; i++) model[i] = '0;
    ARESETN = 1'b0;
    repeat (3) tick();
    outs = {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
            S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, REG_OUT, REG_WR};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", outs);
    end
    @(negedge ACLK);
    ARESETN = 1'b1;
    #1;
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b000) begin
      errors++;
      $display("FAIL ready_before_edge: got %b required 000",
               {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
    end
    tick();
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
      errors++;
      $display("FAIL ready_after_edge: got %b required 111",
               {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
    end
  endtask

  task automatic test_basic();
    logic [1:0]   resp;
    logic [3:0]   wr;
    logic [127:0] rout;
    logic [31:0]  d;
    for (int i = 0; i < 4; i++) begin
      send_aw_w(4'(i*4), 32'(i+1), 4'hF, 1'b1, 1'b1);
      wait_b(resp, wr, rout);
      model[i] = 32'(i+1);
      checks++;
      if (resp !== 2'b00 || wr !== 4'(1 << i)) begin
        errors++;
        $display("FAIL basic_bresp_regwr[%0d]: resp=%b wr=%b required 00 %b", i, resp, wr, 4'(1 << i));
      end
    end
    checks++;
    if (REG_OUT !== 128'h00000004_00000003_00000002_00000001) begin
      errors++;
      $display("FAIL basic_reg_out: got %h required 00000004000000030000000200000001", REG_OUT);
    end
    for (int i = 0; i < 4; i++) begin
      do_read(4'(i*4), d, resp);
      checks++;
      if (d !== 32'(i+1) || resp !== 2'b00) begin
        errors++;
        $display("FAIL basic_read[%0d]: data=%h resp=%b required %h 00", i, d, resp, 32'(i+1));
      end
    end
  endtask

  task automatic test_strobes();
    logic [1:0]   resp;
    logic [3:0]   wr;
    logic [127:0] rout;
    logic [31:0]  d;
    send_aw_w(4'h8, 32'hAABBCCDD, 4'b1111, 1'b1, 1'b1);
    wait_b(resp, wr, rout);
    model[2] = merge(model[2], 32'hAABBCCDD, 4'b1111);
    checks++;
    if (wr !== 4'b0100) begin
      errors++;
      $display("FAIL strobe_regwr_1: got %b required 0100", wr);
    end
    send_aw_w(4'h8, 32'h11223344, 4'b0101, 1'b1, 1'b1);
    wait_b(resp, wr, rout);
    model[2] = merge(model[2], 32'h11223344, 4'b0101);
    checks++;
    if (wr !== 4'b0100) begin
      errors++;
      $display("FAIL strobe_regwr_2: got %b required 0100", wr);
    end
    checks++;
    if (REG_WR !== 4'b0000) begin
      errors++;
      $display("FAIL strobe_regwr_pulse_width: got %b required 0000", REG_WR);
    end
    do_read(4'h8, d, resp);
    checks++;
    if (d !== 32'hAA22CC44) begin
      errors++;
      $display("FAIL strobe_read: got %h required aa22cc44", d);
    end
  endtask

  task automatic test_channel_order(input bit w_first);
    logic [1:0]   resp;
    logic [3:0]   wr;
    logic [127:0] rout;
    int           bcount;
    logic [3:0]   wr_seen;
    send_aw_w(4'h4, 32'h0, 4'hF, 1'b1, 1'b1);
    wait_b(resp, wr, rout);
    model[1] = 32'h0;
    // first channel only
    send_aw_w(4'h4, 32'h5A5A5A5A, 4'hF, !w_first, w_first);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ((w_first ? S_AXI_WREADY : S_AXI_AWREADY) !== 1'b0 || S_AXI_BVALID !== 1'b0) begin
        errors++;
        $display("FAIL order_wait(w_first=%0b,cyc=%0d): ready=%b bvalid=%b required 0 0",
                 w_first, c, w_first ? S_AXI_WREADY : S_AXI_AWREADY, S_AXI_BVALID);
      end
      tick();
    end
    send_aw_w(4'h4, 32'h5A5A5A5A, 4'hF, w_first, !w_first);
    model[1] = 32'h5A5A5A5A;
    bcount  = 0;
    wr_seen = '0;
    for (int c = 0; c < 8; c++) begin
      if (S_AXI_BVALID && S_AXI_BREADY) bcount++;
      wr_seen |= REG_WR;
      tick();
    end
    checks++;
    if (bcount != 1 || wr_seen !== 4'b0010 || REG_OUT !== model_flat()) begin
      errors++;
      $display("FAIL order_result(w_first=%0b): bresp_count=%0d regwr=%b reg_out=%h required 1 0010 %h",
               w_first, bcount, wr_seen, REG_OUT, model_flat());
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d1, d2;
    int          bcount, n;
    d1 = $urandom;
    d2 = $urandom;
    S_AXI_BREADY = 1'b0;
    send_aw_w(4'h0, d1, 4'hF, 1'b1, 1'b1);
    n = 0;
    while (!S_AXI_BVALID && n < 20) begin tick(); n++; end
    model[0] = d1;
    send_aw_w(4'hC, d2, 4'hF, 1'b1, 1'b1);
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (REG_OUT !== model_flat() || REG_WR !== 4'b0000 || S_AXI_BVALID !== 1'b1) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: reg_out=%h regwr=%b bvalid=%b required %h 0000 1",
                 c, REG_OUT, REG_WR, S_AXI_BVALID, model_flat());
      end
      tick();
    end
    S_AXI_BREADY = 1'b1;
    model[3] = d2;
    bcount = 0;
    for (int c = 0; c < 8; c++) begin
      if (S_AXI_BVALID && S_AXI_BREADY) bcount++;
      tick();
    end
    checks++;
    if (bcount != 2 || REG_OUT !== model_flat()) begin
      errors++;
      $display("FAIL backpressure_release: b_handshakes=%0d reg_out=%h required 2 %h",
               bcount, REG_OUT, model_flat());
    end
  endtask

  task automatic test_collision();
    logic [1:0]   resp;
    logic [3:0]   wr;
    logic [127:0] rout;
    logic [31:0]  d;
    send_aw_w(4'h8, 32'h0, 4'hF, 1'b1, 1'b1);
    wait_b(resp, wr, rout);
    model[2] = 32'h0;
    // Both write channels handshake at edge N (buffers empty, readies high),
    // so the commit lands at N+1 together with this AR handshake.
    send_aw_w(4'h8, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b1);
    S_AXI_ARADDR  = 4'h8;
    S_AXI_ARVALID = 1'b1;
    checks++;
    if (S_AXI_ARREADY !== 1'b1) begin
      errors++;
      $display("FAIL collision_arready: got %b required 1", S_AXI_ARREADY);
    end
    tick();
    S_AXI_ARVALID = 1'b0;
    checks++;
    if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'h0 || S_AXI_BVALID !== 1'b1) begin
      errors++;
      $display("FAIL collision_old_value: rvalid=%b rdata=%h bvalid=%b required 1 00000000 1",
               S_AXI_RVALID, S_AXI_RDATA, S_AXI_BVALID);
    end
    model[2] = 32'hFFFFFFFF;
    tick();
    do_read(4'h8, d, resp);
    checks++;
    if (d !== 32'hFFFFFFFF || REG_OUT !== model_flat()) begin
      errors++;
      $display("FAIL collision_new_value: rdata=%h reg_out=%h required ffffffff %h", d, REG_OUT, model_flat());
    end
  endtask

  task automatic test_random();
    logic [1:0]   resp;
    logic [3:0]   wr;
    logic [127:0] rout;
    logic [31:0]  d, data;
    logic [3:0]   addr, strb;
    int           op, idx;
    for (int it = 0; it < 40; it++) begin
      op   = $urandom_range(0, 2);
      addr = 4'($urandom);
      idx  = int'(addr[3:2]);
      if (op == 2) begin
        do_read(addr, d, resp);
        checks++;
        if (d !== model[idx] || resp !== 2'b00) begin
          errors++;
          $display("FAIL rand_read[%0d] addr=%h: data=%h resp=%b required %h 00", it, addr, d, resp, model[idx]);
        end
      end else begin
        data = $urandom;
        strb = 4'($urandom);
        if (op == 0) begin
          send_aw_w(addr, data, strb, 1'b1, 1'b1);
        end else begin
          send_aw_w(addr, data, strb, 1'b1, 1'b0);
          repeat ($urandom_range(0, 3)) tick();
          send_aw_w(addr, data, strb, 1'b0, 1'b1);
        end
        wait_b(resp, wr, rout);
        model[idx] = merge(model[idx], data, strb);
        checks++;
        if (resp !== 2'b00 || wr !== 4'(1 << idx) || rout !== model_flat()) begin
          errors++;
          $display("FAIL rand_write[%0d] addr=%h: resp=%b wr=%b reg_out=%h required 00 %b %h",
                   it, addr, resp, wr, rout, 4'(1 << idx), model_flat());
        end
      end
    end
  endtask

  task automatic test_reset_midop();
    logic [177:0] outs;
    logic [1:0]   resp;
    logic [3:0]   wr;
    logic [127:0] rout;
    logic [31:0]  d, data;
    bit           bseen;
    send_aw_w(4'h0, 32'hDEADBEEF, 4'hF, 1'b1, 1'b1);
    wait_b(resp, wr, rout);
    model[0] = 32'hDEADBEEF;
    send_aw_w(4'h4, 32'h0, 4'h0, 1'b1, 1'b0);
    S_AXI_RREADY  = 1'b0;
    S_AXI_ARADDR  = 4'h0;
    S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_ARVALID = 1'b0;
    checks++;
    if (S_AXI_RVALID !== 1'b1 || S_AXI_AWREADY !== 1'b0) begin
      errors++;
      $display("FAIL midop_setup: rvalid=%b awready=%b required 1 0", S_AXI_RVALID, S_AXI_AWREADY);
    end
    #2;
    ARESETN = 1'b0;
    #1;
    outs = {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
            S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, REG_OUT, REG_WR};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL midop_async_clear: got %h required 0", outs);
    end
    for (int i = 0; i < 4; i++) model[i] = '0;
    S_AXI_RREADY = 1'b1;
    tick();
    ARESETN = 1'b1;
    tick();
    // A lone W must not pair with the discarded AW.
    data = $urandom;
    send_aw_w(4'h4, data, 4'hF, 1'b0, 1'b1);
    bseen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (S_AXI_BVALID) bseen = 1'b1;
      tick();
    end
    checks++;
    if (bseen || REG_OUT !== model_flat()) begin
      errors++;
      $display("FAIL midop_aw_discarded: bvalid_seen=%0b reg_out=%h required 0 %h", bseen, REG_OUT, model_flat());
    end
    send_aw_w(4'h4, data, 4'hF, 1'b1, 1'b0);
    wait_b(resp, wr, rout);
    model[1] = data;
    do_read(4'h0, d, resp);
    checks++;
    if (d !== 32'h0 || REG_OUT !== model_flat()) begin
      errors++;
      $display("FAIL midop_read_after: rdata=%h reg_out=%h required 00000000 %h", d, REG_OUT, model_flat());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_strobes();
    test_channel_order(1'b0);
    test_channel_order(1'b1);
    test_backpressure();
    test_collision();
    test_random();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/myip_s_axil_regfile.md
Name: myip_s_axil_regfile

Overview:
AXI4-Lite slave register file that sits directly downstream of the myip_v1_0 bus masters and terminates their write/read traffic. It holds four 32-bit software-visible registers at byte offsets 0x0, 0x4, 0x8 and 0xC. It accepts AW and W independently, returns OKAY responses, and exports the register contents plus per-register write strobes to the IP core logic.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 supported
C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register, bits [1:0] are ignored

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESETN  in  1  asynchronous active-low reset
S_AXI_AWADDR  in  4  write address
S_AXI_AWPROT  in  3  accepted, ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response; always 2'b00
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  4  read address
S_AXI_ARPROT  in  3  accepted, ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response; always 2'b00
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
REG_OUT  out  128  {reg3,reg2,reg1,reg0}, registered
REG_WR  out  4  one-cycle pulse per register on commit

Behaviour:
- ARESETN low (asynchronous): all outputs 0; reg0..reg3 = 0; AW/W holding buffers empty.
- Ready timing: all READY outputs are registered. AWREADY, WREADY and ARREADY rise on the first edge after ARESETN deasserts.
- Write, AW buffer: one entry. AWREADY = AW buffer empty. An AW handshake at edge E loads the buffer; AWREADY is low from E.
- Write, W buffer: one entry. Data and strobe are held the same way; WREADY = W buffer empty.
- Write, commit condition: both buffers full AND (BVALID=0 OR BREADY=1) at edge C.
- Write, at commit edge C:
  - reg[addr[3:2]] byte k <= wdata byte k where wstrb[k]=1; other bytes hold.
  - REG_WR bit set for exactly one cycle.
  - BVALID <= 1.
  - Both buffers cleared; AWREADY and WREADY <= 1.
- Write, BVALID: held until the BREADY handshake. Throughput is one write per 2 cycles with BREADY tied high.
- Write, ordering: AW may precede W, W may precede AW, or both may arrive in the same cycle.
  - AW first: AW is held with AWREADY low until W arrives.
  - W first: symmetric.
  - Same cycle, handshake at N: commit at N+1 edge; BVALID and the new REG_OUT visible in the cycle after.
- Write, backpressure: BVALID=1 and BREADY=0 with both buffers full -> no commit and registers unchanged until BREADY.
- Read, ARREADY: ARREADY = (RVALID=0) and no read in flight.
- Read, AR handshake at edge E:
  - RDATA <= reg[araddr[3:2]] as of edge E, before any write committing on E.
  - RVALID <= 1 and ARREADY <= 0.
- Read, response: RVALID holds and RDATA is stable until the RREADY handshake; ARREADY re-asserts on that edge.
- Read/write same edge: a write commit and a read capture on one edge to the same register -> read returns the old value.
- Read/write independence: the read and write paths are independent; neither stalls the other.
- Reset mid-transaction: all state cleared at once; pending buffered AW/W and outstanding B/R responses are discarded.
- REG_OUT timing: REG_OUT changes only on a commit edge.
- REG_WR: REG_WR is 0 except in the cycle after a commit.

Test Plan:
- Reset release; AWREADY/WREADY/ARREADY go 1 on the first edge after ARESETN=1.
  - Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read all four -> RDATA 0x1..0x4, BRESP=RRESP=0, REG_OUT=0x00000004_00000003_00000002_00000001.
- Byte strobes: write 0xAABBCCDD to 0x8 with WSTRB=4'b1111, then 0x11223344 with WSTRB=4'b0101 -> read 0x8 = 0xAA22CC44; REG_WR=4'b0100 for one cycle each write.
- Channel order:
  - AW to 0x4 three cycles before W=0x5A5A5A5A -> AWREADY low while waiting, single BVALID after W, reg1=0x5A5A5A5A.
  - Repeat with W first -> same result.
- B backpressure: BREADY=0 for 10 cycles after the first write; issue a second AW/W -> second write not committed (reg unchanged) until BREADY=1, then exactly two B handshakes.
- Read/write same-edge collision: reg2=0x0 and a write of 0xFFFFFFFF to 0x8 commits on the same edge as an AR to 0x8 -> RDATA=0x0, subsequent read = 0xFFFFFFFF.
- Reset mid-op: assert ARESETN low while AW is buffered and RVALID=1 with RREADY=0 -> all outputs and registers 0 immediately; after release, read 0x0 returns 0x0.
